// File: rtl/sequence_player_if.sv
// rtl/sequence_player_if.sv - sequence BRAM read port and 128-bit sequence word bus
// master = player side (drives BRAM reads and sequence words), slave = BRAM/slice side.
interface sequence_player_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [127:0]          bram_rdata;
  logic [127:0]          seq_data;
  logic                  seq_valid;

  modport master (
    output bram_en,
    output bram_addr,
    input  bram_rdata,
    output seq_data,
    output seq_valid
  );

  modport slave (
    input  bram_en,
    input  bram_addr,
    output bram_rdata,
    input  seq_data,
    input  seq_valid
  );
endinterface

// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - plays pre-packed sequence words from BRAM at a programmable step length
// Optional ramp-down hold at end of play is enabled by defining SEQ_PLAYER_RAMP_DOWN_EN.
module sequence_player #(
  parameter int ADDR_WIDTH   = 14,
  parameter int BRAM_LATENCY = 2
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
  ,
  parameter int RAMP_DOWN_STEPS = 1
`endif
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           samples_per_step,
  input  logic [ADDR_WIDTH:0]   num_steps,
  input  logic [15:0]           num_periods,
  sequence_player_if.master     bus,
  output logic [31:0]           step_counter,
  output logic                  running,
  output logic                  done
);

  // A step must be long enough for the count-0 read to land in the prefetch register.
  localparam int S_MIN = (BRAM_LATENCY + 2 > 4) ? BRAM_LATENCY + 2 : 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_RUN
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
    ,
    ST_RAMP
`endif
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]             r_sps;
  logic [ADDR_WIDTH:0]     r_num_steps;
  logic [15:0]             r_num_periods;
  logic [15:0]             r_period;
  logic [31:0]             r_cnt;
  logic [ADDR_WIDTH-1:0]   r_cur_addr;
  logic [ADDR_WIDTH-1:0]   r_bram_addr;
  logic                    r_bram_en;
  logic [BRAM_LATENCY-1:0] r_rd_pipe;
  logic [127:0]            r_pf_data;
  logic                    r_pf_valid;
  logic [127:0]            r_seq_data;
  logic                    r_seq_valid;
  logic [31:0]             r_step_counter;
  logic                    r_stop_req;
  logic                    r_done;
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
  logic [15:0]             r_ramp_cnt;
`endif

  logic [31:0]           w_sps_clamped;
  logic [ADDR_WIDTH:0]   w_last_addr;
  logic [ADDR_WIDTH-1:0] w_next_rd_addr;
  logic                  w_cur_is_last;
  logic                  w_last_step;
  logic                  w_step_end;
  logic                  w_counting;
  logic                  w_start_ok;
  logic                  w_load;
  logic                  w_finish;
  logic                  w_enter_ramp;

  assign w_sps_clamped  = (samples_per_step < 32'(S_MIN)) ? 32'(S_MIN) : samples_per_step;
  assign w_last_addr    = r_num_steps - (ADDR_WIDTH+1)'(1);
  assign w_next_rd_addr = ({1'b0, r_bram_addr} == w_last_addr) ? '0 : r_bram_addr + ADDR_WIDTH'(1);
  assign w_cur_is_last  = ({1'b0, r_cur_addr} == w_last_addr);
  assign w_last_step    = w_cur_is_last && (r_num_periods != 16'd0) &&
                          (r_period == r_num_periods - 16'd1);
  assign w_step_end     = (r_cnt == r_sps - 32'd1);
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
  assign w_counting     = (r_state == ST_RUN) || (r_state == ST_RAMP);
`else
  assign w_counting     = (r_state == ST_RUN);
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    w_load       = 1'b0;
    w_finish     = 1'b0;
    w_enter_ramp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop && (num_steps != '0)) begin
          w_start_ok   = 1'b1;
          w_next_state = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        if (r_pf_valid) begin
          w_load       = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_step_end) begin
          if (r_stop_req || w_last_step) begin
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
            w_enter_ramp = 1'b1;
            w_next_state = ST_RAMP;
`else
            w_finish     = 1'b1;
            w_next_state = ST_IDLE;
`endif
          end else begin
            w_load = 1'b1;
          end
        end
      end
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
      ST_RAMP: begin
        if (w_step_end && (r_ramp_cnt == 16'(RAMP_DOWN_STEPS - 1))) begin
          w_finish     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sps          <= '0;
      r_num_steps    <= '0;
      r_num_periods  <= '0;
      r_period       <= '0;
      r_cnt          <= '0;
      r_cur_addr     <= '0;
      r_bram_addr    <= '0;
      r_bram_en      <= 1'b0;
      r_rd_pipe      <= '0;
      r_pf_data      <= '0;
      r_pf_valid     <= 1'b0;
      r_seq_data     <= '0;
      r_seq_valid    <= 1'b0;
      r_step_counter <= '0;
      r_stop_req     <= 1'b0;
      r_done         <= 1'b0;
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
      r_ramp_cnt     <= '0;
`endif
    end else begin
      r_done    <= w_finish;
      r_bram_en <= 1'b0;
      // Tracks each issued read through the BRAM pipeline to know when rdata is ours.
      r_rd_pipe <= (r_rd_pipe << 1) | BRAM_LATENCY'(r_bram_en);
      if (r_rd_pipe[BRAM_LATENCY-1]) begin
        r_pf_data  <= bus.bram_rdata;
        r_pf_valid <= 1'b1;
      end

      if ((r_state == ST_PREFETCH) || (r_state == ST_RUN)) begin
        r_stop_req <= r_stop_req | stop;
      end

      if (w_counting) begin
        r_cnt <= w_step_end ? '0 : r_cnt + 32'd1;
      end else begin
        r_cnt <= '0;
      end

      if (w_start_ok) begin
        r_sps          <= w_sps_clamped;
        r_num_steps    <= num_steps;
        r_num_periods  <= num_periods;
        r_period       <= '0;
        r_step_counter <= '0;
        r_stop_req     <= 1'b0;
        r_pf_valid     <= 1'b0;
        r_bram_en      <= 1'b1;
        r_bram_addr    <= '0;
      end

      // r_bram_addr still names the prefetched word, so it becomes the current address.
      if (w_load) begin
        r_seq_data     <= r_pf_data;
        r_seq_valid    <= 1'b1;
        r_pf_valid     <= 1'b0;
        r_step_counter <= r_step_counter + 32'd1;
        r_cur_addr     <= r_bram_addr;
        r_bram_addr    <= w_next_rd_addr;
        r_bram_en      <= 1'b1;
        if ((r_state == ST_RUN) && w_cur_is_last) begin
          r_period <= r_period + 16'd1;
        end
      end

`ifdef SEQ_PLAYER_RAMP_DOWN_EN
      if (w_enter_ramp) begin
        r_seq_data <= {r_seq_data[127:114], 2'b11, r_seq_data[111:0]};
        r_ramp_cnt <= '0;
      end else if ((r_state == ST_RAMP) && w_step_end) begin
        r_ramp_cnt <= r_ramp_cnt + 16'd1;
      end
`endif

      if (w_finish) begin
        r_seq_data  <= '0;
        r_seq_valid <= 1'b0;
      end
    end
  end

  assign bus.bram_en   = r_bram_en;
  assign bus.bram_addr = r_bram_addr;
  assign bus.seq_data  = r_seq_data;
  assign bus.seq_valid = r_seq_valid;
  assign step_counter  = r_step_counter;
  assign running       = (r_state != ST_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_sequence_player.sv
// tb/tb_sequence_player.sv - directed and randomized checks of sequence_player against a timeline model
// The model derives every expected word from start-edge offset, step length and table contents.
`timescale 1ns/1ps
module tb_sequence_player;
  localparam int AW = 14;
  localparam int L  = 2;
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
  localparam int RAMP = 2;
`else
  localparam int RAMP = 0;
`endif

  logic            clk = 1'b0;
  logic            clk_en = 1'b1;
  logic            aresetn = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [31:0]     samples_per_step = '0;
  logic [AW:0]     num_steps = '0;
  logic [15:0]     num_periods = '0;
  logic [31:0]     step_counter;
  logic            running;
  logic            done;
  logic [127:0]    mem [0:63];
  logic [127:0]    rd_pipe [0:L-1];
  int              n_vec = 0;
  int              n_err = 0;

  sequence_player_if #(.ADDR_WIDTH(AW)) bus ();

  sequence_player #(
    .ADDR_WIDTH(AW),
    .BRAM_LATENCY(L)
`ifdef SEQ_PLAYER_RAMP_DOWN_EN
    ,
    .RAMP_DOWN_STEPS(RAMP)
`endif
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .start(start),
    .stop(stop),
    .samples_per_step(samples_per_step),
    .num_steps(num_steps),
    .num_periods(num_periods),
    .bus(bus),
    .step_counter(step_counter),
    .running(running),
    .done(done)
  );

  always #5 if (clk_en) clk = ~clk;

  // BRAM with L cycles of read latency from the edge that samples bram_en.
  always @(posedge clk) begin
    if (bus.bram_en) rd_pipe[0] <= mem[bus.bram_addr[5:0]];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.bram_rdata = rd_pipe[L-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " seq_data"},  bus.seq_data, 128'h0);
    check({tag, " seq_valid"}, 128'(bus.seq_valid), 128'h0);
    check({tag, " step_cnt"},  128'(step_counter), 128'h0);
    check({tag, " running"},   128'(running), 128'h0);
    check({tag, " done"},      128'(done), 128'h0);
    check({tag, " bram_en"},   128'(bus.bram_en), 128'h0);
    check({tag, " bram_addr"}, 128'(bus.bram_addr), 128'h0);
  endtask

  // j counts negedges after the start edge E0; inputs set at negedge j are seen at edge E0+j+1.
  task automatic run_play(input int n, input int sps, input int periods,
                          input int stop_step, input int restart_j, input string tag);
    int s, total, j_first, j_end, stop_j, idx;
    logic [127:0] w, exp_data;
    logic exp_valid;
    int exp_sc;
    s       = (sps < 4) ? 4 : sps;
    total   = (stop_step != 0) ? stop_step : n * periods;
    j_first = L + 2;
    j_end   = j_first + (total + RAMP) * s;
    stop_j  = (stop_step != 0) ? j_first + (stop_step - 1) * s + 3 : -1;
    samples_per_step = 32'(sps);
    num_steps        = (AW+1)'(n);
    num_periods      = 16'(periods);
    @(negedge clk);
    start = 1'b1;
    for (int j = 0; j <= j_end + 1; j++) begin
      @(negedge clk);
      start = (j == restart_j);
      stop  = (j == stop_j);
      if (j < j_first) begin
        exp_data = '0; exp_valid = 1'b0; exp_sc = 0;
      end else if (j < j_first + total * s) begin
        idx = (j - j_first) / s;
        exp_data = mem[idx % n]; exp_valid = 1'b1; exp_sc = idx + 1;
      end else if (j < j_end) begin
        w = mem[(total - 1) % n];
        exp_data = {w[127:114], 2'b11, w[111:0]}; exp_valid = 1'b1; exp_sc = total;
      end else begin
        exp_data = '0; exp_valid = 1'b0; exp_sc = total;
      end
      if (j == 0) begin
        check($sformatf("%s bram_en j=0", tag), 128'(bus.bram_en), 128'h1);
        check($sformatf("%s bram_addr j=0", tag), 128'(bus.bram_addr), 128'h0);
      end
      check($sformatf("%s seq_data j=%0d", tag, j), bus.seq_data, exp_data);
      check($sformatf("%s seq_valid j=%0d", tag, j), 128'(bus.seq_valid), 128'(exp_valid));
      check($sformatf("%s step_cnt j=%0d", tag, j), 128'(step_counter), 128'(exp_sc));
      check($sformatf("%s done j=%0d", tag, j), 128'(done), 128'(j == j_end));
      check($sformatf("%s running j=%0d", tag, j), 128'(running), 128'(j < j_end));
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {96'h0, 32'(i)};
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    aresetn = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_play(3, 10, 2, 0, -1, "latency");

    fill_random();
    run_play(4, 1, 1, 0, -1, "clamp");

    fill_random();
    run_play(6, 7, 0, 5, L + 2 + 9, "stop");

    samples_per_step = 32'd8; num_steps = '0; num_periods = 16'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("zero_steps running", 128'(running), 128'h0);
    check("zero_steps bram_en", 128'(bus.bram_en), 128'h0);
    repeat (3) @(negedge clk);
    check("zero_steps seq_valid", 128'(bus.seq_valid), 128'h0);

    num_steps = (AW+1)'(3);
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    check("start_stop running", 128'(running), 128'h0);
    check("start_stop bram_en", 128'(bus.bram_en), 128'h0);
    repeat (6) @(negedge clk);
    check("start_stop seq_valid", 128'(bus.seq_valid), 128'h0);

    fill_random();
    run_play(1, 5, 3, 0, -1, "single_word");

    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_play($urandom_range(1, 12), $urandom_range(1, 9), $urandom_range(1, 3), 0, -1,
               $sformatf("rand%0d", k));
    end

    fill_random();
    samples_per_step = 32'd8; num_steps = (AW+1)'(4); num_periods = 16'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (L + 2 + 3) @(negedge clk);
    check("areset pre seq_valid", 128'(bus.seq_valid), 128'h1);
    check("areset pre running", 128'(running), 128'h1);
    clk_en = 1'b0;
    #2 aresetn = 1'b0;
    #1 check_all_zero("areset");
    #3 aresetn = 1'b1;
    clk_en = 1'b1;
    @(negedge clk);
    fill_random();
    run_play(5, 6, 1, 0, -1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
